lock_entry_sender: RTL

- Front-end for the lock's password path. Debounces and edge-detects the enter/submit/clear buttons and captures switch symbols into a small entry buffer.
- On submit, transmits the buffered symbols serially to the downstream checker over a valid/ready handshake, flagging the final symbol with tx_last.
- Sits between the board buttons/switches and the code-checking logic. It is the sending end of the symbol stream the checker consumes.

---
 rtl/lock_entry_sender.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/lock_entry_sender.sv
// Lock password front-end: debounces the enter/submit/clear buttons, collects switch
// symbols into a small buffer and streams them to the code checker over valid/ready.
module lock_entry_sender #(
    parameter int SYM_W           = 2,
    parameter int MAX_LEN         = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic             clk,
    input  logic             system_reset_n,
    input  logic             key_enter,
    input  logic             key_submit,
    input  logic             key_clear,
    input  logic [SYM_W-1:0] bits,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [SYM_W-1:0] tx_sym,
    output logic             tx_last,
    output logic [2:0]       entry_len,
    output logic             busy,
    output logic             overflow,
    output logic             done
);

    localparam int              IDX_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int              KEY_ENTER  = 0;
    localparam int              KEY_SUBMIT = 1;
    localparam int              KEY_CLEAR  = 2;
    localparam logic [2:0]      LEN_MAX    = 3'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SEND    = 2'd1,
        DONE    = 2'd2
    } state_t;

    logic [2:0] key_raw;
    logic [2:0] press;

    assign key_raw = {key_clear, key_submit, key_enter};

    // Per button: 2-flop synchronizer, stability counter, then a rising-edge pulse of the
    // accepted level; the pulse is registered so it reaches the FSM one cycle after the level.
    for (genvar k = 0; k < 3; k++) begin : g_key
        logic             sync_a;
        logic             sync_b;
        logic             level;
        logic             level_d;
        logic             press_q;
        logic [CNT_W-1:0] db_cnt;

        always_ff @(posedge clk or negedge system_reset_n) begin
            if (!system_reset_n) begin
                sync_a  <= 1'b0;
                sync_b  <= 1'b0;
                level   <= 1'b0;
                level_d <= 1'b0;
                press_q <= 1'b0;
                db_cnt  <= '0;
            end else begin
                sync_a  <= key_raw[k];
                sync_b  <= sync_a;
                level_d <= level;
                press_q <= level & ~level_d;
                if (sync_b == level) begin
                    db_cnt <= '0;
                end else if (db_cnt == CNT_LAST) begin
                    level  <= sync_b;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + CNT_W'(1);
                end
            end
        end

        assign press[k] = press_q;
    end

    state_t           state;
    state_t           state_next;
    logic [2:0]       len_q;
    logic [2:0]       len_next;
    logic [2:0]       idx_q;
    logic [2:0]       idx_next;
    logic             ovf_q;
    logic             ovf_next;
    logic             wr_en;
    logic             last_sym;
    logic [IDX_W-1:0] wr_addr;
    logic [IDX_W-1:0] rd_addr;
    logic [SYM_W-1:0] sym_buf [MAX_LEN];

    assign wr_addr  = len_q[IDX_W-1:0];
    assign rd_addr  = idx_q[IDX_W-1:0];
    assign last_sym = (idx_q == len_q - 3'd1);

    // Only COLLECT reacts to buttons (clear beats submit beats enter); SEND and DONE drop them.
    always_comb begin
        state_next = state;
        len_next   = len_q;
        idx_next   = idx_q;
        ovf_next   = ovf_q;
        wr_en      = 1'b0;
        case (state)
            COLLECT: begin
                if (press[KEY_CLEAR]) begin
                    len_next = 3'd0;
                    ovf_next = 1'b0;
                end else if (press[KEY_SUBMIT]) begin
                    if (len_q != 3'd0) begin
                        state_next = SEND;
                        idx_next   = 3'd0;
                    end
                end else if (press[KEY_ENTER]) begin
                    if (len_q < LEN_MAX) begin
                        wr_en    = 1'b1;
                        len_next = len_q + 3'd1;
                    end else begin
                        ovf_next = 1'b1;
                    end
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (last_sym) begin
                        state_next = DONE;
                    end else begin
                        idx_next = idx_q + 3'd1;
                    end
                end
            end
            DONE: begin
                state_next = COLLECT;
                len_next   = 3'd0;
                ovf_next   = 1'b0;
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state <= COLLECT;
            len_q <= 3'd0;
            idx_q <= 3'd0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_next;
            len_q <= len_next;
            idx_q <= idx_next;
            ovf_q <= ovf_next;
        end
    end

    // A clear only rewinds the length; stale symbols are never read past entry_len.
    always_ff @(posedge clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                sym_buf[i] <= '0;
            end
        end else if (wr_en) begin
            sym_buf[wr_addr] <= bits;
        end
    end

    assign tx_valid  = (state == SEND);
    assign busy      = (state == SEND);
    assign done      = (state == DONE);
    assign tx_sym    = tx_valid ? sym_buf[rd_addr] : '0;
    assign tx_last   = tx_valid & last_sym;
    assign entry_len = len_q;
    assign overflow  = ovf_q;

endmodule
